// File: rtl/vga_capture.sv
// VGA receive-side capture: recovers pixel coordinates from the syncs, checks timing and locks.
// Ports: clk, reset (async, active-low), vga_h_sync/v_sync/R/G/B in; pixel stream, lock, checksum out.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic [3:0]  vga_R,
    input  logic [3:0]  vga_G,
    input  logic [3:0]  vga_B,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_sum,
    output logic        sum_valid
);

    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // stage 1
    logic        hs_q, hs_p_q, vs_q, vs_p_q;
    logic [11:0] rgb_q;
    // counters / control
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        v_pend_q, v_pend_d;
    state_t      state_q, state_d;
    logic        bad_q, bad_d;
    logic [15:0] acc_q, acc_d;
    // stage 2 outputs
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        timing_err_q, timing_err_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic        sum_valid_q, sum_valid_d;

    logic h_edge, v_edge, boundary, line_err, frame_err, err, active;

    always_comb begin
        h_edge   = hs_p_q & ~hs_q;
        v_edge   = vs_p_q & ~vs_q;
        boundary = h_edge & (v_pend_q | v_edge);
        v_pend_d = ~boundary & (v_pend_q | v_edge);

        h_cnt_d = h_cnt_q;
        if (h_edge)                h_cnt_d = '0;
        else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;

        // Saturation is flagged once, on the clock that reaches the ceiling.
        line_err = h_edge ? (h_cnt_q != H_LAST) : (h_cnt_q == CNT_MAX - 10'd1);

        v_cnt_d = v_cnt_q;
        if (boundary)                           v_cnt_d = '0;
        else if (h_edge && v_cnt_q != CNT_MAX)  v_cnt_d = v_cnt_q + 10'd1;

        frame_err = boundary & (v_cnt_q != V_LAST);
        err       = line_err | frame_err;

        active = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                 (v_cnt_d >= V_START) && (v_cnt_d < V_END);

        pix_x_d = active ? h_cnt_d - H_START : '0;
        pix_y_d = active ? v_cnt_d - V_START : '0;

        state_d       = state_q;
        bad_d         = bad_q;
        acc_d         = acc_q;
        frame_sum_d   = frame_sum_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        timing_err_d  = 1'b0;
        sum_valid_d   = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (boundary) begin
                    state_d = CHECK;
                    bad_d   = 1'b0;
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (!bad_q && !err) begin
                        state_d = LOCKED;
                        acc_d   = '0;
                    end else begin
                        bad_d = 1'b0;
                    end
                end else if (line_err) begin
                    bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if (err) begin
                    // partial frame is dropped, no checksum reported
                    state_d      = SEARCH;
                    timing_err_d = 1'b1;
                    acc_d        = '0;
                end else begin
                    pix_valid_d = active;
                    if (boundary) begin
                        frame_sum_d   = acc_q;
                        sum_valid_d   = 1'b1;
                        frame_start_d = 1'b1;
                        acc_d         = active ? {4'h0, rgb_q} : 16'h0000;
                    end else if (active) begin
                        acc_d = acc_q + {4'h0, rgb_q};
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q          <= 1'b0;
            hs_p_q        <= 1'b0;
            vs_q          <= 1'b0;
            vs_p_q        <= 1'b0;
            rgb_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            v_pend_q      <= 1'b0;
            state_q       <= SEARCH;
            bad_q         <= 1'b0;
            acc_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            frame_sum_q   <= '0;
            sum_valid_q   <= 1'b0;
        end else begin
            hs_q          <= vga_h_sync;
            hs_p_q        <= hs_q;
            vs_q          <= vga_v_sync;
            vs_p_q        <= vs_q;
            rgb_q         <= {vga_R, vga_G, vga_B};
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            v_pend_q      <= v_pend_d;
            state_q       <= state_d;
            bad_q         <= bad_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= rgb_q;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
            frame_sum_q   <= frame_sum_d;
            sum_valid_q   <= sum_valid_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign frame_sum   = frame_sum_q;
    assign sum_valid   = sum_valid_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 16x12 timing (8x6 visible).
// Generator drives syncs/RGB on negedges; outputs are sampled on negedges.
module tb_vga_capture;

    localparam int HA = 8;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VA = 6;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VT = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic [3:0]  r = '0, g = '0, b = '0;
    logic        pix_valid, frame_start, locked, timing_err, sum_valid;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_sum;

    vga_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_h_sync(hs), .vga_v_sync(vs),
        .vga_R(r), .vga_G(g), .vga_B(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .timing_err(timing_err), .frame_sum(frame_sum),
        .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_sv, n_terr, n_fs, n_valid;
    int n_coord = 0;
    logic [15:0] last_sum;
    logic [9:0]  hx [2];
    logic [9:0]  hy [2];
    logic [11:0] hrgb [2];
    logic        hact [2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pat(input int mode, input int x);
        if (mode == 0) return 12'h001;
        if (x < 3) return 12'h00F;
        if (x < 6) return 12'hFFF;
        return 12'hF00;
    endfunction

    task automatic clr();
        n_sv = 0; n_terr = 0; n_fs = 0; n_valid = 0;
    endtask

    // Sample outputs, then drive the next generator position.
    // Outputs at this negedge belong to the inputs driven two ticks earlier.
    task automatic tick(input logic s_h, input logic s_v, input int gh,
                        input int gv, input int mode);
        logic act;
        logic [11:0] c;
        @(negedge clk);
        if (sum_valid) begin n_sv++; last_sum = frame_sum; end
        if (timing_err) n_terr++;
        if (frame_start) n_fs++;
        if (pix_valid) begin
            n_valid++;
            if (!hact[1] || pix_x !== hx[1] || pix_y !== hy[1] ||
                pix_rgb !== hrgb[1]) n_coord++;
        end
        act = gh >= HS + HB && gh < HS + HB + HA &&
              gv >= VS + VB && gv < VS + VB + VA;
        c = act ? pat(mode, gh - HS - HB) : 12'h000;
        hx[1] = hx[0]; hy[1] = hy[0]; hrgb[1] = hrgb[0]; hact[1] = hact[0];
        hx[0] = 10'(gh - HS - HB);
        hy[0] = 10'(gv - VS - VB);
        hrgb[0] = c;
        hact[0] = act;
        hs = s_h;
        vs = s_v;
        {r, g, b} = c;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b1, 0, -1, 0);
    endtask

    task automatic line(input int gv, input int len, input int mode);
        for (int h = 0; h < len; h++)
            tick(h >= HS, gv >= VS, h, gv, mode);
    endtask

    task automatic frame(input int nlines, input int short_ln,
                         input int short_len, input int mode);
        clr();
        for (int v = 0; v < nlines; v++)
            line(v, (v == short_ln) ? short_len : HT, mode);
    endtask

    initial begin
        hact[0] = 0; hact[1] = 0;
        hx[0] = 0; hx[1] = 0; hy[0] = 0; hy[1] = 0;
        hrgb[0] = 0; hrgb[1] = 0;
        clr();
        last_sum = 16'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 0);
        chk("rst_flags", {frame_start, locked, timing_err, sum_valid}, 0);
        chk("rst_sum", frame_sum, 0);
        reset = 1'b1;
        idle(3);

        // ideal timing, constant 0x001
        frame(VT, -1, 0, 0);
        chk("f1_locked", locked, 0);
        chk("f1_valid", n_valid, 0);
        chk("f1_sv", n_sv, 0);
        frame(VT, -1, 0, 0);
        chk("f2_locked", locked, 1);
        chk("f2_valid", n_valid, 48);
        chk("f2_sv", n_sv, 0);
        chk("f2_fs", n_fs, 0);
        frame(VT, -1, 0, 0);
        chk("f3_sv", n_sv, 1);
        chk("f3_sum", last_sum, 16'h0030);
        chk("f3_fs", n_fs, 1);
        chk("f3_terr", n_terr, 0);

        // stripes, coordinate and latency checks
        frame(VT, -1, 0, 1);
        chk("f4_sum", last_sum, 16'h0030);
        chk("f4_valid", n_valid, 48);
        chk("f4_coord", n_coord, 0);
        frame(VT, -1, 0, 1);
        chk("f5_sv", n_sv, 1);
        chk("f5_sum", last_sum, 16'hD4FC);
        chk("f5_coord", n_coord, 0);

        // short line while locked
        frame(VT, 3, HT - 1, 1);
        chk("f6_sv", n_sv, 1);
        chk("f6_sum", last_sum, 16'hD4FC);
        chk("f6_terr", n_terr, 1);
        chk("f6_locked", locked, 0);
        frame(VT, -1, 0, 1);
        chk("f7_sv", n_sv, 0);
        chk("f7_locked", locked, 0);
        frame(VT, -1, 0, 1);
        chk("f8_locked", locked, 1);
        chk("f8_sv", n_sv, 0);
        frame(VT, -1, 0, 1);
        chk("f9_sv", n_sv, 1);
        chk("f9_sum", last_sum, 16'hD4FC);

        // short frame, then a bad line during CHECK
        frame(VT - 1, -1, 0, 0);
        chk("f10_sv", n_sv, 1);
        chk("f10_locked", locked, 1);
        frame(VT, -1, 0, 0);
        chk("f11_terr", n_terr, 1);
        chk("f11_sv", n_sv, 0);
        chk("f11_fs", n_fs, 0);
        chk("f11_locked", locked, 0);
        frame(VT, 5, HT - 2, 0);
        chk("f12_locked", locked, 0);
        frame(VT, -1, 0, 0);
        chk("f13_locked", locked, 0);
        frame(VT, -1, 0, 0);
        chk("f14_locked", locked, 1);

        // h_sync stuck high past saturation
        clr();
        idle(1100);
        chk("hold_terr", n_terr, 1);
        chk("hold_locked", locked, 0);
        chk("hold_sv", n_sv, 0);
        frame(VT, -1, 0, 0);
        chk("f15_locked", locked, 0);
        frame(VT, -1, 0, 1);
        chk("f16_locked", locked, 1);

        // async reset in the middle of an active line
        frame(5, -1, 0, 1);
        chk("p_sv", n_sv, 1);
        chk("p_sum", last_sum, 16'hD4FC);
        for (int h = 0; h <= 6; h++) tick(h >= HS, 1'b1, h, 5, 1);
        chk("pre_rst_valid", pix_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 0);
        chk("mid_rst_flags", {frame_start, locked, timing_err, sum_valid}, 0);
        chk("mid_rst_sum", frame_sum, 0);
        idle(2);
        reset = 1'b1;
        idle(3);
        frame(VT, -1, 0, 0);
        chk("ra_locked", locked, 0);
        chk("ra_sv", n_sv, 0);
        frame(VT, -1, 0, 0);
        chk("rb_locked", locked, 1);
        chk("rb_sv", n_sv, 0);
        frame(VT, -1, 0, 0);
        chk("rc_sv", n_sv, 1);
        chk("rc_sum", last_sum, 16'h0030);

        chk("all_coord", n_coord, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
